// File: rtl/ysyx_23060124_lsu_pkg.sv
// Shared definitions for the LSU AXI4-Lite master: access size codes,
// AXI response codes and the transaction FSM state encoding.
package ysyx_23060124_lsu_pkg;

    // req_size encodings
    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_ILL = 2'd3;

    // AXI xRESP codes
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW_W,
        ST_B,
        ST_RESP
    } state_e;

endpackage

// File: rtl/ysyx_23060124_lsu_lane.sv
// Byte-lane steering for a 32-bit bus (purely combinational).
//   off, size : low address bits and access size of the access
//   sext      : sign-extend narrow loads
//   st_data   : right-aligned store data -> wdata (lane-replicated), wstrb
//   ld_word   : raw bus read word        -> ld_data (extracted, extended)
//   misalign  : access not naturally aligned, or illegal size
module ysyx_23060124_lsu_lane
    import ysyx_23060124_lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic        misalign,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    // Addressed byte/half moved down to bit 0
    logic [15:0] ld_low;
    assign ld_low = 16'(ld_word >> {off, 3'b000});

    always_comb begin
        misalign = 1'b0;
        wstrb    = 4'h0;
        wdata    = st_data;
        ld_data  = 32'h0;
        case (size)
            SZ_B: begin
                wstrb   = 4'b0001 << off;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{sext & ld_low[7]}}, ld_low[7:0]};
            end
            SZ_H: begin
                misalign = off[0];
                wstrb    = 4'b0011 << off;
                wdata    = {2{st_data[15:0]}};
                ld_data  = {{16{sext & ld_low[15]}}, ld_low[15:0]};
            end
            SZ_W: begin
                misalign = (off != 2'd0);
                wstrb    = 4'hF;
                ld_data  = ld_word;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_23060124_lsu_axi_master.sv
// AXI4-Lite master serving one LSU load/store at a time.
//   req_*  : LSU request (valid/ready), latched on accept
//   rsp_*  : one response per request, held until rsp_ready
//   m_ar*/m_r*          : AXI read address / data channels
//   m_aw*/m_w*/m_b*     : AXI write address / data / response channels
// Misaligned or illegal-size requests respond with rsp_err without bus traffic.
// The lane logic is fixed at 32 bits, so DATA_W must stay 32.
module ysyx_23060124_lsu_axi_master
    import ysyx_23060124_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                req_wen,
    input  logic [1:0]          req_size,
    input  logic                req_sext,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                sext_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                aw_done_q;
    logic                w_done_q;

    logic                idle;
    logic [1:0]          lane_off;
    logic [1:0]          lane_size;
    logic                lane_misalign;
    logic [3:0]          lane_wstrb;
    logic [31:0]         lane_wdata;
    logic [31:0]         lane_rdata;

    assign idle = (state_q == ST_IDLE);

    // Lane logic sees the incoming request while idle, the latched one afterwards
    assign lane_off  = idle ? req_addr[1:0] : addr_q[1:0];
    assign lane_size = idle ? req_size      : size_q;

    ysyx_23060124_lsu_lane u_lane (
        .off      (lane_off),
        .size     (lane_size),
        .sext     (sext_q),
        .st_data  (req_wdata),
        .ld_word  (m_rdata),
        .misalign (lane_misalign),
        .wstrb    (lane_wstrb),
        .wdata    (lane_wdata),
        .ld_data  (lane_rdata)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; AW and W may complete in either order or together
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (lane_misalign) state_d = ST_RESP;
                    else if (req_wen)  state_d = ST_AW_W;
                    else               state_d = ST_AR;
                end
            end
            ST_AR:   if (m_arready) state_d = ST_R;
            ST_R:    if (m_rvalid)  state_d = ST_RESP;
            ST_AW_W: if ((aw_done_q || m_awready) && (w_done_q || m_wready)) state_d = ST_B;
            ST_B:    if (m_bvalid)  state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, handshake bookkeeping and response capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q    <= '0;
            size_q    <= '0;
            sext_q    <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        sext_q    <= req_sext;
                        wdata_q   <= (req_wen && !lane_misalign) ? DATA_W'(lane_wdata) : '0;
                        wstrb_q   <= (req_wen && !lane_misalign) ? STRB_W'(lane_wstrb) : '0;
                        rdata_q   <= '0;
                        err_q     <= lane_misalign;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                ST_AW_W: begin
                    if (m_awvalid && m_awready) aw_done_q <= 1'b1;
                    if (m_wvalid && m_wready)   w_done_q  <= 1'b1;
                end
                ST_R: begin
                    if (m_rvalid) begin
                        err_q   <= (m_rresp != RESP_OKAY);
                        rdata_q <= (m_rresp == RESP_OKAY) ? DATA_W'(lane_rdata) : '0;
                    end
                end
                ST_B: begin
                    if (m_bvalid) err_q <= (m_bresp != RESP_OKAY);
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from registers
    assign req_ready = idle;
    assign m_arvalid = (state_q == ST_AR);
    assign m_araddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign m_rready  = (state_q == ST_R);
    assign m_awvalid = (state_q == ST_AW_W) && !aw_done_q;
    assign m_awaddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign m_wvalid  = (state_q == ST_AW_W) && !w_done_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_bready  = (state_q == ST_B);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060124_lsu_axi_master.sv
// Randomized bench with an in-bench AXI slave and a behavioural reference
// model of each request's bus payload, response and latency.
module tb_ysyx_23060124_lsu_axi_master;

    logic        i_clk;
    logic        i_rst_n;
    logic        req_valid, req_ready, req_wen, req_sext;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_rresp, m_bresp;
    logic [3:0]  m_wstrb;

    ysyx_23060124_lsu_axi_master dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wen(req_wen), .req_size(req_size), .req_sext(req_sext),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic misal(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0);
    endfunction

    function automatic logic [31:0] ld_model(input logic [31:0] a, input logic [1:0] sz,
                                             input logic sx, input logic [31:0] w);
        int n, off;
        logic [31:0] v, m;
        n   = 1 << sz;
        off = int'(a & 32'd3);
        v   = w >> (8 * off);
        if (n < 4) begin
            m = (32'd1 << (8 * n)) - 32'd1;
            v = v & m;
            if (sx && v[8*n-1]) v = v | ~m;
        end
        return v;
    endfunction

    function automatic logic [31:0] wdata_model(input logic [31:0] wd, input logic [1:0] sz);
        int n;
        logic [31:0] r;
        n = 1 << sz;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] wstrb_model(input logic [31:0] a, input logic [1:0] sz);
        int n, off;
        logic [3:0] r;
        n   = 1 << sz;
        off = int'(a & 32'd3);
        for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + n);
        return r;
    endfunction

    // Current request expectations (kind: 0 no bus, 1 read, 2 write)
    int          exp_kind;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_wstrb;
    logic        exp_err;
    logic        chk_en = 1'b0;

    // ---------------- handshake monitor ----------------
    int          n_ar = 0, n_aw = 0, n_w = 0;
    logic        ar_f, r_f, aw_f, w_f, b_f;
    logic [31:0] cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ar_f <= 1'b0; r_f <= 1'b0; aw_f <= 1'b0; w_f <= 1'b0; b_f <= 1'b0;
        end else begin
            ar_f <= m_arvalid && m_arready;
            r_f  <= m_rvalid && m_rready;
            aw_f <= m_awvalid && m_awready;
            w_f  <= m_wvalid && m_wready;
            b_f  <= m_bvalid && m_bready;
            if (m_arvalid && m_arready) n_ar <= n_ar + 1;
            if (m_awvalid && m_awready) begin n_aw <= n_aw + 1; cap_awaddr <= m_awaddr; end
            if (m_wvalid && m_wready) begin
                n_w <= n_w + 1; cap_wdata <= m_wdata; cap_wstrb <= m_wstrb;
            end
        end
    end

    // ---------------- AXI slave ----------------
    int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
    logic [31:0] sl_rdata;
    logic [1:0]  sl_rresp, sl_bresp;
    logic        r_pend, b_pend, got_aw, got_w;

    task automatic slave_clear();
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        r_pend = 1'b0; b_pend = 1'b0; got_aw = 1'b0; got_w = 1'b0;
    endtask

    initial begin
        slave_clear();
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) continue;
            if (r_f) m_rvalid = 1'b0;
            if (ar_f) begin
                m_arready = 1'b0;
                r_pend = 1'b1;
            end else if (m_arvalid && !m_arready) begin
                if (ar_wait == 0) m_arready = 1'b1; else ar_wait--;
            end
            if (r_pend && !m_rvalid) begin
                if (r_wait == 0) begin
                    m_rvalid = 1'b1; m_rdata = sl_rdata; m_rresp = sl_rresp; r_pend = 1'b0;
                end else r_wait--;
            end
            if (aw_f) begin
                m_awready = 1'b0; got_aw = 1'b1;
            end else if (m_awvalid && !m_awready) begin
                if (aw_wait == 0) m_awready = 1'b1; else aw_wait--;
            end
            if (w_f) begin
                m_wready = 1'b0; got_w = 1'b1;
            end else if (m_wvalid && !m_wready) begin
                if (w_wait == 0) m_wready = 1'b1; else w_wait--;
            end
            if (b_f) m_bvalid = 1'b0;
            if (got_aw && got_w) begin
                got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b1;
            end
            if (b_pend && !m_bvalid) begin
                if (b_wait == 0) begin
                    m_bvalid = 1'b1; m_bresp = sl_bresp; b_pend = 1'b0;
                end else b_wait--;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge i_clk);
            #1;
            if (chk_en && i_rst_n) begin
                if (m_arvalid) begin
                    chk("arvalid_kind", 32'(exp_kind), 32'd1);
                    chk("araddr", m_araddr, exp_addr);
                end
                if (m_awvalid) begin
                    chk("awvalid_kind", 32'(exp_kind), 32'd2);
                    chk("awaddr", m_awaddr, exp_addr);
                end
                if (m_wvalid) begin
                    chk("wvalid_kind", 32'(exp_kind), 32'd2);
                    chk("wdata", m_wdata, exp_wdata);
                    chk("wstrb", 32'(m_wstrb), 32'(exp_wstrb));
                end
                if (rsp_valid) begin
                    chk("rsp_rdata", rsp_rdata, exp_rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
                    chk("req_ready_busy", 32'(req_ready), 32'd0);
                end
            end
        end
    end

    // ---------------- request driver ----------------
    task automatic run(input logic [31:0] a, input logic [31:0] wd, input logic wen,
                       input logic [1:0] sz, input logic sx, input logic [31:0] rd,
                       input logic [1:0] rr, input logic [1:0] br,
                       input int d_ar, input int d_r, input int d_aw, input int d_w,
                       input int d_b, input int hold,
                       input logic lit_en, input logic [31:0] lit_rd, input logic lit_err);
        int lat, elat, s_ar, s_aw, s_w;
        logic mis;
        mis       = misal(a, sz);
        exp_kind  = mis ? 0 : (wen ? 2 : 1);
        exp_addr  = a & ~32'd3;
        exp_wdata = wdata_model(wd, sz);
        exp_wstrb = wstrb_model(a, sz);
        exp_err   = mis || (wen ? (br != 2'b00) : (rr != 2'b00));
        exp_rdata = (exp_err || wen) ? 32'h0 : ld_model(a, sz, sx, rd);
        elat = mis ? 1 : (wen ? 3 + ((d_aw > d_w) ? d_aw : d_w) + d_b : 3 + d_ar + d_r);
        ar_wait = d_ar; r_wait = d_r; aw_wait = d_aw; w_wait = d_w; b_wait = d_b;
        sl_rdata = rd; sl_rresp = rr; sl_bresp = br;
        s_ar = n_ar; s_aw = n_aw; s_w = n_w;
        req_addr = a; req_wdata = wd; req_wen = wen; req_size = sz; req_sext = sx;
        req_valid = 1'b1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge i_clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge i_clk);
            lat++;
        end
        chk("rsp_latency", 32'(lat), 32'(elat));
        if (lit_en) begin
            chk("lit_rdata", rsp_rdata, lit_rd);
            chk("lit_err", 32'(rsp_err), 32'(lit_err));
        end
        repeat (hold) @(negedge i_clk);
        rsp_ready = 1'b1;
        @(negedge i_clk);
        rsp_ready = 1'b0;
        chk("rsp_dropped", 32'(rsp_valid), 32'd0);
        chk("req_ready_back", 32'(req_ready), 32'd1);
        chk("ar_count", 32'(n_ar - s_ar), 32'(exp_kind == 1));
        chk("aw_count", 32'(n_aw - s_aw), 32'(exp_kind == 2));
        chk("w_count", 32'(n_w - s_w), 32'(exp_kind == 2));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_valids"}, 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, rsp_valid}), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_addrs"}, m_araddr | m_awaddr, 32'd0);
        chk({tag, "_wdata"}, m_wdata, 32'd0);
        chk({tag, "_wstrb"}, 32'(m_wstrb), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int guard;
        req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wen = 1'b0;
        req_size = 2'd0; req_sext = 1'b0; rsp_ready = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk_en = 1'b1;

        // LB sign-extended from the top byte lane
        run(32'h8000_0003, 32'h0, 1'b0, 2'd0, 1'b1, 32'h80FF_1234, 2'b00, 2'b00,
            0, 0, 0, 0, 0, 0, 1'b1, 32'hFFFF_FF80, 1'b0);
        // LHU from the upper half
        run(32'h8000_0002, 32'h0, 1'b0, 2'd1, 1'b0, 32'hBEEF_0000, 2'b00, 2'b00,
            0, 0, 0, 0, 0, 1, 1'b1, 32'h0000_BEEF, 1'b0);
        // SH with AW delayed three cycles, W immediate
        run(32'h8000_0002, 32'h1234_ABCD, 1'b1, 2'd1, 1'b0, 32'h0, 2'b00, 2'b00,
            0, 0, 3, 0, 0, 0, 1'b1, 32'h0, 1'b0);
        chk("sh_awaddr", cap_awaddr, 32'h8000_0000);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_wstrb", 32'(cap_wstrb), 32'h0000_000C);
        // Misaligned LW: error on cycle 1, no bus traffic
        run(32'h8000_0001, 32'h0, 1'b0, 2'd2, 1'b0, 32'h1111_1111, 2'b00, 2'b00,
            0, 0, 0, 0, 0, 0, 1'b1, 32'h0, 1'b1);
        // SW with SLVERR, response held off for four cycles
        run(32'h8000_0010, 32'hCAFE_F00D, 1'b1, 2'd2, 1'b0, 32'h0, 2'b00, 2'b10,
            0, 0, 0, 0, 0, 4, 1'b1, 32'h0, 1'b1);
        // Load bus error zeroes the data
        run(32'h8000_0020, 32'h0, 1'b0, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b11, 2'b00,
            1, 2, 0, 0, 0, 0, 1'b1, 32'h0, 1'b1);

        // Reset while waiting in R
        run_reset_mid();

        for (int k = 0; k < 150; k++) begin
            logic [1:0] rr, br;
            rr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            br = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run(32'h8000_0000 | ($urandom & 32'hFF), $urandom, 1'($urandom),
                2'($urandom), 1'($urandom), $urandom, rr, br,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'b0, 32'h0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    task automatic run_reset_mid();
        int guard;
        exp_kind = 1; exp_addr = 32'h8000_0040; exp_err = 1'b0;
        ar_wait = 0; r_wait = 6; sl_rdata = 32'h5555_AAAA; sl_rresp = 2'b00;
        req_addr = 32'h8000_0040; req_wen = 1'b0; req_size = 2'd2; req_sext = 1'b0;
        req_valid = 1'b1;
        @(negedge i_clk);
        req_valid = 1'b0;
        guard = 0;
        while (!m_rready && guard < 20) begin
            @(negedge i_clk);
            guard++;
        end
        chk("reach_r_state", 32'(m_rready), 32'd1);
        chk_en = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        slave_clear();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk_en = 1'b1;
        run(32'h8000_0044, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0123_4567, 2'b00, 2'b00,
            0, 0, 0, 0, 0, 0, 1'b1, 32'h0123_4567, 1'b0);
    endtask

endmodule

// File: doc/ysyx_23060124_lsu_axi_master.md
# ysyx_23060124_lsu_axi_master

Bus-side memory access unit directly downstream of the LSU: it replaces the LSU's DPI memory calls with a real AXI4-Lite master. It accepts one load or store request at a time over a valid/ready handshake and performs byte-lane alignment, write strobes, and load extraction with sign/zero extension. It returns a single response per request to the LSU.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; byte lanes = 4)
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  LSU request valid
- req_ready  out  1  request accepted when valid&ready
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- req_sext  in  1  load sign-extend (LB/LH), ignored for stores/words
- rsp_valid  out  1  response valid
- rsp_ready  in  1  LSU accepts response
- rsp_rdata  out  DATA_W  extended load data, 0 for stores/errors
- rsp_err  out  1  misaligned, illegal size, or non-OKAY bus response
- m_araddr/m_arvalid/m_arready  out/out/in  ADDR_W/1/1  AXI read address
- m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  DATA_W/2/1/1  AXI read data
- m_awaddr/m_awvalid/m_awready  out/out/in  ADDR_W/1/1  AXI write address
- m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  DATA_W/4/1/1  AXI write data
- m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  AXI write response

## Operation
- States: IDLE, AR, R, AW_W, B, RESP. req_ready = (state==IDLE).
- On accept, latch addr, wdata, wen, size, sext.
- Misaligned check: half with addr[0]=1, word with addr[1:0]≠0, or size=3 → RESP with err=1. No bus traffic.
- Load: AR (arvalid=1, araddr = addr & ~3) until arready → R (rready=1) until rvalid.
  - Capture rdata>>(8·addr[1:0]), truncate to size, extend per sext.
  - err = (rresp≠0). On err, rsp_rdata=0.
- Store: AW_W drives awvalid and wvalid together. awaddr = addr & ~3.
  - Each valid drops independently after its own handshake. Leave for B once both handshakes are done, including same-cycle completion.
  - wdata: byte {4{b}}, half {2{h}}, word as-is.
  - wstrb: byte 1<<addr[1:0], half 3<<addr[1:0], word 4'hF.
  - B: bready=1 until bvalid. err = (bresp≠0).
- RESP: rsp_valid=1, data and err stable until rsp_ready; then IDLE.
- No new request is accepted while RESP is pending.
- AXI address/data/strobe outputs stay stable while their valid is high.

## Timing
- Reset values:
  - state IDLE, req_ready=1.
  - All m_*valid, m_rready, m_bready, rsp_valid, rsp_err = 0.
  - All address/data outputs 0, m_wstrb 0.
- Zero-wait-state slave, accept at cycle 0:
  - Load: arvalid cycle 1, R cycle 2, rsp_valid cycle 3.
  - Store: aw/w cycle 1, B cycle 2, rsp_valid cycle 3.
  - Misaligned or illegal: rsp_valid cycle 1.
- Back-to-back: with rsp_ready held high, the next request is accepted the cycle after the response handshake.
- rvalid/bvalid arriving before rready/bready is legal; the slave holds them.
- Reset mid-transaction abandons all outstanding bus handshakes; all outputs return to reset values immediately (asynchronous).

## Structure
- Shared package holds: size encodings (SZ_B/SZ_H/SZ_W), FSM state enum, AXI resp codes (OKAY=0).
- One sub-module, ysyx_23060124_lsu_lane (purely combinational):
  - misalign detect, wstrb/wdata generation;
  - load extraction and extension.
- The FSM and registers live in the top.

## Test plan
- LB, addr 0x80000003, sext=1, rdata 0x80FF_1234 → rsp_rdata 0xFFFF_FF80, err 0, rsp_valid cycle 3.
- LHU, addr 0x80000002, rdata 0xBEEF_0000 → 0x0000_BEEF.
- SH, addr 0x80000002, wdata 0x1234ABCD:
  - → awaddr 0x80000000, wdata 0xABCDABCD, wstrb 4'b1100.
  - awready delayed 3 cycles, wready immediate → single response.
- LW at 0x80000001 → rsp_err=1 at cycle 1, arvalid never asserted.
- SW, bresp=2'b10 → rsp_err=1; rsp_ready low 4 cycles → rsp_valid, rsp_err stable, req_ready 0 throughout.
- Assert i_rst_n low during R state → all valids 0 same cycle; after release, a new LW completes normally.
